// File: rtl/glitch_monitor.sv
// Measures trigger-rise to glitch-rise delay and glitch high time in clk cycles.
// Both inputs share one synchroniser depth, so their relative timing is exact.
module glitch_monitor #(
  parameter int          CNT_WIDTH      = 32,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd240_000_000,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 trigger,
  input  logic                 glitch,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] delay_cycles,
  output logic [CNT_WIDTH-1:0] width_cycles
);

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, WIDTH, DONE} state_t;

  // The abort limit is clamped to the counter range so a saturated counter still times out.
  localparam logic [63:0]          CNT_MAX    = (64'd1 << CNT_WIDTH) - 64'd1;
  localparam logic [63:0]          LIMIT_WIDE = ({32'd0, TIMEOUT_CYCLES} > CNT_MAX) ?
                                                CNT_MAX : {32'd0, TIMEOUT_CYCLES};
  localparam logic [CNT_WIDTH-1:0] LIMIT      = LIMIT_WIDE[CNT_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0] ALL_ONES   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] ZERO       = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] ONE        = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state, state_next;
  logic [CNT_WIDTH-1:0]   cnt, cnt_next, cnt_inc;
  logic [CNT_WIDTH-1:0]   delay_next, width_next;
  logic                   timeout_next;

  logic [SYNC_STAGES-1:0] trig_sync, glitch_sync;
  logic                   trig_prev, glitch_prev;
  logic                   trig_rise, glitch_rise, glitch_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_sync   <= '0;
      glitch_sync <= '0;
      trig_prev   <= 1'b0;
      glitch_prev <= 1'b0;
      trig_rise   <= 1'b0;
      glitch_rise <= 1'b0;
      glitch_fall <= 1'b0;
    end else begin
      trig_sync   <= {trig_sync[SYNC_STAGES-2:0], trigger};
      glitch_sync <= {glitch_sync[SYNC_STAGES-2:0], glitch};
      trig_prev   <= trig_sync[SYNC_STAGES-1];
      glitch_prev <= glitch_sync[SYNC_STAGES-1];
      trig_rise   <= trig_sync[SYNC_STAGES-1] & ~trig_prev;
      glitch_rise <= glitch_sync[SYNC_STAGES-1] & ~glitch_prev;
      glitch_fall <= ~glitch_sync[SYNC_STAGES-1] & glitch_prev;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= ZERO;
      delay_cycles <= ZERO;
      width_cycles <= ZERO;
      timeout      <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      delay_cycles <= delay_next;
      width_cycles <= width_next;
      timeout      <= timeout_next;
    end
  end

  assign cnt_inc = (cnt == ALL_ONES) ? cnt : cnt + ONE;

  // Entering DELAY or WIDTH loads 1, so a latched count equals the strobe-to-strobe distance.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    delay_next   = delay_cycles;
    width_next   = width_cycles;
    timeout_next = timeout;
    case (state)
      IDLE: ;
      ARMED: begin
        if (trig_rise && glitch_rise) begin
          state_next = WIDTH;
          delay_next = ZERO;
          cnt_next   = ONE;
        end else if (trig_rise) begin
          state_next = DELAY;
          cnt_next   = ONE;
        end else if (cnt >= LIMIT) begin
          state_next   = DONE;
          timeout_next = 1'b1;
          delay_next   = ALL_ONES;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      DELAY: begin
        if (glitch_rise) begin
          state_next = WIDTH;
          delay_next = cnt;
          cnt_next   = ONE;
        end else if (cnt >= LIMIT) begin
          state_next   = DONE;
          timeout_next = 1'b1;
          delay_next   = ALL_ONES;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      WIDTH: begin
        if (glitch_fall) begin
          state_next = DONE;
          width_next = cnt;
        end else if (cnt >= LIMIT) begin
          state_next   = DONE;
          timeout_next = 1'b1;
          width_next   = ALL_ONES;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      DONE: ;
      default: state_next = IDLE;
    endcase
    // arm overrides any edge seen in the same cycle and restarts from a clean slate.
    if (arm) begin
      state_next   = ARMED;
      cnt_next     = ZERO;
      delay_next   = ZERO;
      width_next   = ZERO;
      timeout_next = 1'b0;
    end
  end

  assign busy = (state == ARMED) || (state == DELAY) || (state == WIDTH);
  assign done = (state == DONE);

endmodule

// File: tb/tb_glitch_monitor.sv
// Directed bench for glitch_monitor with a short timeout and 16-bit counters.
// Inputs change 1 time unit after a rising edge so both lines keep exact cycle alignment.
module tb_glitch_monitor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         arm;
  logic         trigger;
  logic         glitch;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [W-1:0] delay_cycles;
  logic [W-1:0] width_cycles;

  int checks = 0;
  int errors = 0;
  int n;

  glitch_monitor #(
    .CNT_WIDTH(W),
    .TIMEOUT_CYCLES(32'd100),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .trigger(trigger),
    .glitch(glitch),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .delay_cycles(delay_cycles),
    .width_cycles(width_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic trig_val, input logic glitch_val, input int cycles);
    trigger = trig_val;
    glitch  = glitch_val;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseArm();
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("done_reached", 32'(done), 32'd1);
  endtask

  // Absolute watchdog in case a bounded wait is somehow bypassed.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; trigger = 1'b0; glitch = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",    32'(busy),         32'd0);
    checkOutput("reset_done",    32'(done),         32'd0);
    checkOutput("reset_timeout", 32'(timeout),      32'd0);
    checkOutput("reset_delay",   32'(delay_cycles), 32'd0);
    checkOutput("reset_width",   32'(width_cycles), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 3);

    $display("[TB] basic 12/12 measurement");
    pulseArm();
    checkOutput("basic_busy_armed", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b0, 12);
    applyStimulus(1'b1, 1'b1, 12);
    applyStimulus(1'b1, 1'b0, 0);
    waitDone(30, n);
    checkOutput("basic_busy_done", 32'(busy),         32'd0);
    checkOutput("basic_timeout",   32'(timeout),      32'd0);
    checkOutput("basic_delay",     32'(delay_cycles), 32'd12);
    checkOutput("basic_width",     32'(width_cycles), 32'd12);
    applyStimulus(1'b0, 1'b0, 5);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 5);
    checkOutput("held_done",  32'(done),         32'd1);
    checkOutput("held_delay", 32'(delay_cycles), 32'd12);
    checkOutput("held_width", 32'(width_cycles), 32'd12);
    pulseArm();
    checkOutput("rearm_done",  32'(done),         32'd0);
    checkOutput("rearm_busy",  32'(busy),         32'd1);
    checkOutput("rearm_delay", 32'(delay_cycles), 32'd0);
    checkOutput("rearm_width", 32'(width_cycles), 32'd0);

    $display("[TB] glitch level before trigger");
    applyStimulus(1'b0, 1'b1, 5);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 0);
    waitDone(30, n);
    checkOutput("level_delay", 32'(delay_cycles), 32'd5);
    checkOutput("level_width", 32'(width_cycles), 32'd3);

    $display("[TB] same-cycle trigger and glitch");
    applyStimulus(1'b0, 1'b0, 5);
    pulseArm();
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b1, 1'b0, 0);
    waitDone(30, n);
    checkOutput("same_delay",   32'(delay_cycles), 32'd0);
    checkOutput("same_width",   32'(width_cycles), 32'd4);
    checkOutput("same_timeout", 32'(timeout),      32'd0);

    $display("[TB] timeout in DELAY");
    applyStimulus(1'b0, 1'b0, 5);
    pulseArm();
    applyStimulus(1'b1, 1'b0, 0);
    waitDone(300, n);
    checkOutput("to_latency", 32'(n),            32'd104);
    checkOutput("to_timeout", 32'(timeout),      32'd1);
    checkOutput("to_delay",   32'(delay_cycles), 32'hFFFF);
    checkOutput("to_width",   32'(width_cycles), 32'd0);
    checkOutput("to_busy",    32'(busy),         32'd0);

    $display("[TB] reset during WIDTH");
    applyStimulus(1'b0, 1'b0, 5);
    pulseArm();
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b1, 1'b1, 5);
    checkOutput("rstw_busy_before",  32'(busy),         32'd1);
    checkOutput("rstw_delay_before", 32'(delay_cycles), 32'd6);
    rst = 1'b1;
    #2;
    checkOutput("rstw_busy",    32'(busy),         32'd0);
    checkOutput("rstw_done",    32'(done),         32'd0);
    checkOutput("rstw_timeout", 32'(timeout),      32'd0);
    checkOutput("rstw_delay",   32'(delay_cycles), 32'd0);
    checkOutput("rstw_width",   32'(width_cycles), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("rstw_idle_busy", 32'(busy), 32'd0);
    checkOutput("rstw_idle_done", 32'(done), 32'd0);

    $display("[TB] arm mid-DELAY");
    applyStimulus(1'b0, 1'b0, 5);
    pulseArm();
    applyStimulus(1'b1, 1'b0, 10);
    pulseArm();
    checkOutput("midarm_busy",  32'(busy),         32'd1);
    checkOutput("midarm_delay", 32'(delay_cycles), 32'd0);
    applyStimulus(1'b1, 1'b1, 6);
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("midarm_still_busy", 32'(busy), 32'd1);
    checkOutput("midarm_not_done",   32'(done), 32'd0);
    applyStimulus(1'b0, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 7);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 0);
    waitDone(30, n);
    checkOutput("midarm_new_delay", 32'(delay_cycles), 32'd7);
    checkOutput("midarm_new_width", 32'(width_cycles), 32'd2);
    checkOutput("midarm_timeout",   32'(timeout),      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
